// File: rtl/quad_frontend.sv
// Quadrature encoder front end: 2-flop sync, per-channel stability filter, INIT/RUN FSM, inc/dec/err strobes.
// Latency: a held pin change updates a_filt/b_filt on edge FILTER_LEN+2; the strobe follows one edge later.
// Backpressure: none; strobes are single-cycle and err_cnt saturates. QUAD_X4_EN selects 4x decoding (default 2x).
module quad_frontend #(
   parameter int FILTER_LEN = 4,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             A,
   input  logic             B,
   input  logic             err_clr,
   output logic             inc,
   output logic             dec,
   output logic             a_filt,
   output logic             b_filt,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             ready
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [7:0]       CNT_LAST = 8'(FILTER_LEN - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;
   localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

   // Index 0 is channel A, index 1 is channel B.
   logic [1:0] sync1;      // first synchronizer stage
   logic [1:0] ab_s;       // synchronized levels {b_s, a_s}
   logic [1:0] ab_sd;      // synchronized levels one cycle earlier
   logic [1:0] filt;       // filtered levels
   logic [1:0] filt_prev;  // filtered levels one cycle earlier
   logic [1:0] ld;         // channel has received its first filtered value
   logic [1:0] warm;       // ab_s holds sampled pin data once warm[1] is set
   logic [7:0] cnt [2];    // per-channel stability counters
   state_t     state;

   logic chg_a;
   logic chg_b;
   logic illegal;

   assign a_filt  = filt[0];
   assign b_filt  = filt[1];
   assign chg_a   = filt[0] ^ filt_prev[0];
   assign chg_b   = filt[1] ^ filt_prev[1];
   assign illegal = (state == RUN) && chg_a && chg_b;

   // Synchronize both pins and qualify each level by FILTER_LEN consecutive stable samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         ab_s  <= '0;
         ab_sd <= '0;
         filt  <= '0;
         ld    <= '0;
         warm  <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1 <= {B, A};
         ab_s  <= sync1;
         ab_sd <= ab_s;
         warm  <= {warm[0], 1'b1};
         for (int i = 0; i < 2; i++) begin
            if (!ld[i]) begin
               // First load: time how long ab_s has held its current level, ignoring
               // the reset-value samples that precede real pin data.
               if (warm[1]) begin
                  if (ab_s[i] != ab_sd[i]) begin
                     cnt[i] <= 8'd1;
                  end else if (cnt[i] == CNT_LAST) begin
                     filt[i] <= ab_s[i];
                     ld[i]   <= 1'b1;
                     cnt[i]  <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 8'd1;
                  end
               end
            end else if (ab_s[i] == filt[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               filt[i] <= ab_s[i];
               cnt[i]  <= '0;
            end else begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   // INIT/RUN state machine with registered direction/error strobes and saturating error count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= INIT;
         ready     <= 1'b0;
         inc       <= 1'b0;
         dec       <= 1'b0;
         err       <= 1'b0;
         err_cnt   <= '0;
         filt_prev <= '0;
      end else begin
         filt_prev <= filt;
         inc       <= 1'b0;
         dec       <= 1'b0;
         err       <= 1'b0;
         case (state)
            INIT: begin
               if (&ld) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               if (chg_a && chg_b) begin
                  err <= 1'b1;
               end else if (chg_a) begin
                  inc <= (filt[0] == filt[1]);
                  dec <= (filt[0] != filt[1]);
               end else if (chg_b) begin
`ifdef QUAD_X4_EN
                  inc <= (filt[0] != filt[1]);
                  dec <= (filt[0] == filt[1]);
`else
                  // 2x decoding counts on channel A edges only.
                  inc <= 1'b0;
                  dec <= 1'b0;
`endif
               end
            end
            default: begin
               state <= INIT;
               ready <= 1'b0;
            end
         endcase
         // A clear that coincides with an illegal transition keeps that one event.
         if (err_clr) begin
            err_cnt <= illegal ? ERR_ONE : '0;
         end else if (illegal && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_ONE;
         end
      end
   end

endmodule

// File: doc/quad_frontend.md
QUAD_FRONTEND -- requirements
Module: quad_frontend

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, number of consecutive stable cycles (2..255) required before a synchronized input is accepted.
REQ-002 SHALL have parameter ERR_W, default 8, width of the illegal-transition counter.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz CLOCK_50 domain); the block uses this single clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port A  input  1  raw encoder channel A (asynchronous to clk).
REQ-006 SHALL have port B  input  1  raw encoder channel B (asynchronous to clk).
REQ-007 SHALL have port err_clr  input  1  synchronous clear of err_cnt.
REQ-008 SHALL have port inc  output  1  one-cycle strobe, one count forward.
REQ-009 SHALL have port dec  output  1  one-cycle strobe, one count backward.
REQ-010 SHALL have port a_filt  output  1  filtered channel A.
REQ-011 SHALL have port b_filt  output  1  filtered channel B.
REQ-012 SHALL have port err  output  1  one-cycle strobe on an illegal transition.
REQ-013 SHALL have port err_cnt  output  ERR_W  saturating illegal-transition count.
REQ-014 SHALL have port ready  output  1  high once the state machine is in RUN.

Function
REQ-015 SHALL pass A and B each through a 2-flop synchronizer; the outputs are a_s and b_s.
REQ-016 SHALL keep a per-channel stability counter: cleared when a_s equals a_filt; otherwise incremented; when a_s has differed for FILTER_LEN consecutive cycles, a_filt is loaded with a_s and the counter is cleared (same rule for b_s and b_filt).
REQ-017 SHALL make a pin change held stable update a_filt/b_filt on the (FILTER_LEN+2)th rising clk edge after the change; with default parameters, inc/dec/err assert during the 7th cycle.
REQ-018 SHALL reject any pulse shorter than FILTER_LEN cycles after synchronization, leaving the filtered outputs and strobes unchanged.
REQ-019 SHALL implement a state machine with states INIT and RUN: INIT loads a_filt/b_filt from the first values held stable for FILTER_LEN cycles and generates no strobes; the machine enters RUN once both channels have been loaded; RUN persists until reset.
REQ-020 SHALL, in RUN, register the strobes from the previous and current (a_filt, b_filt).
REQ-021 SHALL, in RUN, on an a_filt change alone, assert inc if a_filt==b_filt after the change, else assert dec.
REQ-022 SHALL, in RUN, on a b_filt change alone, assert inc if a_filt!=b_filt after the change, else assert dec (gated by REQ-030).
REQ-023 SHALL treat a change of both a_filt and b_filt in the same cycle as illegal: no inc/dec, err asserted for 1 cycle, err_cnt incremented.
REQ-024 SHALL keep inc, dec and err mutually exclusive, each high for exactly 1 cycle per event.
REQ-025 SHALL saturate err_cnt at 2^ERR_W-1, with no wrap-around.
REQ-026 SHALL clear err_cnt to 0 on err_clr; on err_clr coinciding with an illegal transition, err_cnt becomes 1.
REQ-027 SHALL drive ready high exactly in RUN.

Reset
REQ-028 SHALL asynchronously force, on reset high: synchronizer flops, stability counters, a_filt, b_filt, inc, dec, err, err_cnt and ready to 0, and the state machine to INIT.
REQ-029 SHALL, on reset asserted mid-operation, drop any pending stability count and strobe; after release the block re-enters INIT and produces no strobe for the pin level present at release.

Configuration
REQ-030 SHALL use macro QUAD_X4_EN: defined gives 4x decoding (REQ-021 and REQ-022 both active, 4 counts per quadrature cycle); undefined gives 2x decoding (only REQ-021 active; b_filt-only changes produce no strobe), with illegal detection (REQ-023) active in both builds.

Verification
REQ-031 SHALL cover: A=B=1 at reset release, held -> ready=1 on cycle 7, zero strobes.
REQ-032 SHALL cover: from RUN with AB=01, forward sequence 01->11->10->00->01, 20 cycles per step -> QUAD_X4_EN: 4 inc, 0 dec; undefined: 2 inc.
REQ-033 SHALL cover: reverse sequence 00->10->11->01->00 -> QUAD_X4_EN: 4 dec; undefined: 2 dec; inc never high.
REQ-034 SHALL cover: 3-cycle high glitch on A with FILTER_LEN=4 -> a_filt unchanged, no strobe.
REQ-035 SHALL cover: AB 00->11 simultaneously, 300 times with ERR_W=8 -> 300 err strobes, err_cnt=255; err_clr pulse -> err_cnt=0.
REQ-036 SHALL cover: reset asserted 2 cycles after an A edge -> no inc/dec issued; after release ready=0 until both channels have been stable for FILTER_LEN cycles.
